// File: rtl/speed_level_controller.sv
// Speed level controller for the snake game.
// Runs the game FSM and counts eaten food. Once a full group of food has
// been eaten, one level step is armed. The step is applied on the next
// synchronised slow_clock rising edge (game_tick), so the speed never
// changes in the middle of a slow_clock period.
`timescale 1ns/1ps

module speed_level_controller #(
   parameter int unsigned FOODS_PER_LEVEL = 4,
   parameter logic [2:0]  START_LEVEL     = 3'd0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       food_eaten,
   input  logic       collision,
   input  logic       slow_clock,
   output logic [2:0] level,
   output logic       game_tick,
   output logic       level_up,
   output logic [1:0] state,
   output logic [3:0] food_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      OVER   = 2'b11
   } state_t;

   localparam logic [3:0] LAST_FOOD = 4'(FOODS_PER_LEVEL - 1);
   localparam logic [2:0] MAX_LEVEL = 3'd7;

   state_t     state_reg;
   logic [2:0] level_reg;
   logic [3:0] food_count_reg;
   logic       pending_reg;
   logic       game_tick_reg;
   logic       level_up_reg;

   // slow_clock synchroniser (s1, s2) plus history flop s3 for edge detection
   logic s1_reg;
   logic s2_reg;
   logic s3_reg;

   logic       tick_next;
   logic       run_quiet;
   logic       step;
   logic [2:0] level_after;
   logic       food_counted;
   logic       group_done;

   // Bring slow_clock into the clock domain and keep one sample of history
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= slow_clock;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   // Decode this cycle's tick, level step and food accounting
   always_comb begin
      tick_next    = s2_reg & ~s3_reg & (state_reg == RUN);
      // A collision or pause leaves RUN, so food and level steps are dropped
      run_quiet    = (state_reg == RUN) & ~collision & ~pause;
      step         = run_quiet & tick_next & pending_reg & (level_reg != MAX_LEVEL);
      level_after  = step ? (level_reg + 3'd1) : level_reg;
      food_counted = run_quiet & food_eaten;
      group_done   = food_counted & (food_count_reg == LAST_FOOD);
   end

   // Game FSM with level, food counter and pending-step bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         level_reg      <= START_LEVEL;
         food_count_reg <= 4'd0;
         pending_reg    <= 1'b0;
         game_tick_reg  <= 1'b0;
         level_up_reg   <= 1'b0;
      end else begin
         game_tick_reg <= tick_next;
         level_up_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg      <= RUN;
                  level_reg      <= START_LEVEL;
                  food_count_reg <= 4'd0;
                  pending_reg    <= 1'b0;
               end
            end
            RUN: begin
               if (collision) begin
                  state_reg <= OVER;
               end else if (pause) begin
                  state_reg <= PAUSED;
               end else begin
                  level_reg    <= level_after;
                  level_up_reg <= step;
                  if (food_counted) begin
                     food_count_reg <= group_done ? 4'd0 : (food_count_reg + 4'd1);
                  end
                  // A group finished on a tick cycle arms the next tick, not this one;
                  // judging against the post-step level keeps level from passing 7
                  if (group_done && (level_after != MAX_LEVEL)) begin
                     pending_reg <= 1'b1;
                  end else if (step) begin
                     pending_reg <= 1'b0;
                  end
               end
            end
            PAUSED: begin
               if (pause) begin
                  state_reg <= RUN;
               end
            end
            OVER: begin
               if (start) begin
                  state_reg      <= RUN;
                  level_reg      <= START_LEVEL;
                  food_count_reg <= 4'd0;
                  pending_reg    <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign state      = state_reg;
   assign level      = level_reg;
   assign food_count = food_count_reg;
   assign game_tick  = game_tick_reg;
   assign level_up   = level_up_reg;

endmodule

// File: tb/tb_speed_level_controller.sv
// Self-checking bench for speed_level_controller (default parameters).
`timescale 1ns/1ps

module tb_speed_level_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       food_eaten = 1'b0;
   logic       collision = 1'b0;
   logic       slow_clock = 1'b0;
   logic [2:0] level;
   logic       game_tick;
   logic       level_up;
   logic [1:0] state;
   logic [3:0] food_count;

   int checks = 0;
   int errors = 0;

   speed_level_controller dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .food_eaten (food_eaten),
      .collision  (collision),
      .slow_clock (slow_clock),
      .level      (level),
      .game_tick  (game_tick),
      .level_up   (level_up),
      .state      (state),
      .food_count (food_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         st;
      bit         pa;
      bit         fd;
      bit         co;
      logic [1:0] e_state;
      logic [3:0] e_fc;
      logic [2:0] e_lvl;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Packed snapshot {state, food_count, level, game_tick, level_up}
   function automatic logic [15:0] snap();
      return {5'd0, state, food_count, level, game_tick, level_up};
   endfunction

   function automatic logic [15:0] pack(input int st, input int fc, input int lv, input int gt, input int lu);
      return {5'd0, 2'(st), 4'(fc), 3'(lv), 1'(gt), 1'(lu)};
   endfunction

   // Apply one set of pulses for exactly one rising edge, then sample 1 ns later
   task automatic drive(input bit st, input bit pa, input bit fd, input bit co);
      @(negedge clock);
      start = st; pause = pa; food_eaten = fd; collision = co;
      @(posedge clock);
      #1;
      start = 1'b0; pause = 1'b0; food_eaten = 1'b0; collision = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; slow_clock = 1'b0;
      start = 1'b0; pause = 1'b0; food_eaten = 1'b0; collision = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // One full slow_clock period; counts ticks and level steps seen
   task automatic slow_pulse(output int ticks, output int lus);
      ticks = 0; lus = 0;
      slow_clock = 1'b1;
      repeat (5) begin
         drive(0, 0, 0, 0);
         ticks += int'(game_tick);
         lus   += int'(level_up);
      end
      slow_clock = 1'b0;
      repeat (5) begin
         drive(0, 0, 0, 0);
         ticks += int'(game_tick);
         lus   += int'(level_up);
      end
   endtask

   // Reference model state for the random run
   int m_state, m_lvl, m_fc, m_pend;
   bit samp[$];

   initial begin
      int tk, lu;
      int half, cnt;
      bit st, pa, fd, co, tick;
      int exp_lu;

      // ---- reset state ----
      reset = 1'b1;
      #3;
      check("reset_async", snap(), pack(0, 0, 0, 0, 0));
      repeat (2) @(posedge clock);
      #1;
      check("reset_held", snap(), pack(0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 1'b0;

      // ---- table-driven FSM/food sequence (slow_clock idle) ----
      vecs[0]  = '{1, 0, 0, 0, 2'd1, 4'd0, 3'd0}; // start
      vecs[1]  = '{0, 0, 1, 0, 2'd1, 4'd1, 3'd0};
      vecs[2]  = '{0, 0, 1, 0, 2'd1, 4'd2, 3'd0};
      vecs[3]  = '{0, 1, 1, 0, 2'd2, 4'd2, 3'd0}; // pause wins, food dropped
      vecs[4]  = '{0, 0, 1, 0, 2'd2, 4'd2, 3'd0}; // food ignored in PAUSED
      vecs[5]  = '{0, 0, 0, 1, 2'd2, 4'd2, 3'd0}; // collision ignored in PAUSED
      vecs[6]  = '{0, 1, 0, 0, 2'd1, 4'd2, 3'd0}; // resume
      vecs[7]  = '{0, 0, 1, 0, 2'd1, 4'd3, 3'd0};
      vecs[8]  = '{0, 0, 1, 0, 2'd1, 4'd0, 3'd0}; // group wraps
      vecs[9]  = '{0, 1, 1, 1, 2'd3, 4'd0, 3'd0}; // collision wins
      vecs[10] = '{0, 1, 0, 0, 2'd3, 4'd0, 3'd0}; // pause in OVER
      vecs[11] = '{0, 0, 1, 0, 2'd3, 4'd0, 3'd0};
      vecs[12] = '{1, 0, 0, 0, 2'd1, 4'd0, 3'd0}; // restart
      vecs[13] = '{0, 0, 1, 0, 2'd1, 4'd1, 3'd0};
      vecs[14] = '{0, 0, 0, 0, 2'd1, 4'd1, 3'd0};
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].st, vecs[i].pa, vecs[i].fd, vecs[i].co);
         check($sformatf("vec[%0d]", i), snap(),
               pack(vecs[i].e_state, vecs[i].e_fc, vecs[i].e_lvl, 0, 0));
         $display("vec %0d st=%0d pa=%0d fd=%0d co=%0d -> state=%0d fc=%0d lvl=%0d",
                  i, vecs[i].st, vecs[i].pa, vecs[i].fd, vecs[i].co, state, food_count, level);
      end

      // ---- tick latency and first level step ----
      do_reset();
      drive(1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 1, 0);
         check($sformatf("food_seq[%0d]", i), {12'd0, food_count}, 16'(i % 4));
      end
      slow_clock = 1'b1;
      drive(0, 0, 0, 0);
      check("tick_e0", snap(), pack(1, 0, 0, 0, 0));
      drive(0, 0, 0, 0);
      check("tick_e1", snap(), pack(1, 0, 0, 0, 0));
      drive(0, 0, 0, 0);
      check("tick_e2_step", snap(), pack(1, 0, 1, 1, 1));
      drive(0, 0, 0, 0);
      check("tick_e3", snap(), pack(1, 0, 1, 0, 0));
      slow_clock = 1'b0;
      repeat (4) drive(0, 0, 0, 0);
      $display("latency sequence level=%0d", level);

      // ---- climb to level 7, then saturation ----
      for (int l = 2; l <= 7; l++) begin
         repeat (4) drive(0, 0, 1, 0);
         slow_pulse(tk, lu);
         check($sformatf("climb_lvl%0d", l), {11'd0, 3'(level), 1'b0, 1'(lu)}, {11'd0, 3'(l), 1'b0, 1'b1});
      end
      repeat (4) drive(0, 0, 1, 0);
      check("sat_fc_wrap", {12'd0, food_count}, 16'd0);
      slow_pulse(tk, lu);
      check("sat_level", {13'd0, level}, 16'd7);
      check("sat_no_level_up", 16'(lu), 16'd0);
      check("sat_one_tick", 16'(tk), 16'd1);
      $display("saturation level=%0d level_ups=%0d", level, lu);

      // ---- pause drops ticks, no backlog ----
      drive(0, 1, 0, 0);
      check("pause_state", {14'd0, state}, 16'd2);
      cnt = 0;
      for (int r = 0; r < 3; r++) begin
         slow_pulse(tk, lu);
         cnt += tk;
      end
      drive(0, 0, 1, 0);
      check("pause_ticks", 16'(cnt), 16'd0);
      check("pause_food", {12'd0, food_count}, 16'd0);
      drive(0, 1, 0, 0);
      check("resume_state", {14'd0, state}, 16'd1);
      repeat (3) drive(0, 0, 0, 0);
      check("no_backlog", 16'(game_tick), 16'd0);
      slow_pulse(tk, lu);
      check("resume_tick", 16'(tk), 16'd1);
      $display("pause sequence ticks_while_paused=%0d ticks_after=%0d", cnt, tk);

      // ---- asynchronous reset with a pending step ----
      do_reset();
      drive(1, 0, 0, 0);
      repeat (4) drive(0, 0, 1, 0);
      slow_clock = 1'b1;
      drive(0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_now", snap(), pack(0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 1'b0;
      slow_clock = 1'b0;
      slow_pulse(tk, lu);
      check("after_reset_no_tick", {14'd0, 1'(tk), 1'(lu)}, 16'd0);
      check("after_reset_idle", {14'd0, state}, 16'd0);
      $display("async reset sequence state=%0d ticks=%0d", state, tk);

      // ---- randomized run against the reference model ----
      do_reset();
      m_state = 0; m_lvl = 0; m_fc = 0; m_pend = 0;
      samp = {1'b0, 1'b0, 1'b0};
      half = 3; cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         int k;
         cnt++;
         if (cnt >= half) begin
            slow_clock = ~slow_clock;
            cnt = 0;
            half = $urandom_range(8, 3);
         end
         st = ($urandom_range(19, 0) == 0);
         pa = ($urandom_range(24, 0) == 0);
         fd = ($urandom_range(2, 0) == 0);
         co = ($urandom_range(79, 0) == 0);
         drive(st, pa, fd, co);
         samp.push_back(slow_clock);
         k = samp.size() - 1;
         // A rise first seen at edge k-2 produces the tick at edge k
         tick = samp[k-2] && !samp[k-3] && (m_state == 1);
         exp_lu = 0;
         case (m_state)
            0: if (st) begin m_state = 1; m_lvl = 0; m_fc = 0; m_pend = 0; end
            1: begin
               if (co) m_state = 3;
               else if (pa) m_state = 2;
               else begin
                  if (tick && m_pend == 1 && m_lvl < 7) begin
                     m_lvl++; exp_lu = 1; m_pend = 0;
                  end
                  if (fd) begin
                     m_fc++;
                     if (m_fc == 4) begin
                        m_fc = 0;
                        if (m_lvl < 7) m_pend = 1;
                     end
                  end
               end
            end
            2: if (pa) m_state = 1;
            default: if (st) begin m_state = 1; m_lvl = 0; m_fc = 0; m_pend = 0; end
         endcase
         check($sformatf("rand[%0d]", c), snap(), pack(m_state, m_fc, m_lvl, int'(tick), exp_lu));
         if ((c % 300) == 0)
            $display("rand %0d state=%0d lvl=%0d fc=%0d tick=%0d", c, state, level, food_count, game_tick);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
